// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the pipelined control path.
// Stage bundles are sized by the localparams here; the top-level width
// parameters are expected to keep their default values.
package ctrl_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int ALU_CTRL_W   = 4;
    localparam int RESULT_SRC_W = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_ALU    = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b10
    } jump_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef struct packed {
        logic                    reg_write;
        logic [1:0]              mem_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic [ALU_CTRL_W-1:0]   alu_ctrl;
        logic                    alu_src;
        logic                    branch;
        logic [1:0]              jump;
        logic [REG_ADDR_W-1:0]   rd;
        logic [REG_ADDR_W-1:0]   rs1;
        logic [REG_ADDR_W-1:0]   rs2;
        logic [2:0]              funct3;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // Conditional-branch outcome from the ALU flags, selected by funct3.
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic zero,
                                         input logic lt,
                                         input logic ltu);
        logic cond;
        case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bus between the control path and its surroundings (fetch, decoder, ALU, datapath).
interface ctrl_pipe_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int ALU_CTRL_WIDTH   = 4,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int CNT_WIDTH        = 16
);
    logic [DATA_WIDTH-1:0]       InstrF_i;
    logic [DATA_WIDTH-1:0]       PCF_i;
    logic [DATA_WIDTH-1:0]       PCPlus4F_i;
    logic                        RegWriteD_i;
    logic [1:0]                  MemWriteD_i;
    logic [RESULT_SRC_WIDTH-1:0] ResultSrcD_i;
    logic [ALU_CTRL_WIDTH-1:0]   ALUControlD_i;
    logic                        ALUSrcD_i;
    logic                        BranchD_i;
    logic [1:0]                  JumpD_i;
    logic                        ZeroE_i;
    logic                        LtE_i;
    logic                        LtuE_i;
    logic [DATA_WIDTH-1:0]       InstrD_o;
    logic [DATA_WIDTH-1:0]       PCD_o;
    logic [DATA_WIDTH-1:0]       PCPlus4D_o;
    logic [ALU_CTRL_WIDTH-1:0]   ALUControlE_o;
    logic                        ALUSrcE_o;
    logic [1:0]                  MemWriteM_o;
    logic [2:0]                  funct3M_o;
    logic                        RegWriteW_o;
    logic [RESULT_SRC_WIDTH-1:0] ResultSrcW_o;
    logic [REG_ADDR_WIDTH-1:0]   RdW_o;
    logic [1:0]                  PCSrcE_o;
    logic                        StallF_o;
    logic [1:0]                  ForwardAE_o;
    logic [1:0]                  ForwardBE_o;
    logic [CNT_WIDTH-1:0]        HazardCnt_o;

    modport master (
        output InstrF_i, PCF_i, PCPlus4F_i, RegWriteD_i, MemWriteD_i, ResultSrcD_i,
               ALUControlD_i, ALUSrcD_i, BranchD_i, JumpD_i, ZeroE_i, LtE_i, LtuE_i,
        input  InstrD_o, PCD_o, PCPlus4D_o, ALUControlE_o, ALUSrcE_o, MemWriteM_o,
               funct3M_o, RegWriteW_o, ResultSrcW_o, RdW_o, PCSrcE_o, StallF_o,
               ForwardAE_o, ForwardBE_o, HazardCnt_o
    );

    modport slave (
        input  InstrF_i, PCF_i, PCPlus4F_i, RegWriteD_i, MemWriteD_i, ResultSrcD_i,
               ALUControlD_i, ALUSrcD_i, BranchD_i, JumpD_i, ZeroE_i, LtE_i, LtuE_i,
        output InstrD_o, PCD_o, PCPlus4D_o, ALUControlE_o, ALUSrcE_o, MemWriteM_o,
               funct3M_o, RegWriteW_o, ResultSrcW_o, RdW_o, PCSrcE_o, StallF_o,
               ForwardAE_o, ForwardBE_o, HazardCnt_o
    );
endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard detection: load-use stall, control flush, E-stage forwarding.
module hazard_unit
    import ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0]   rs1_d_i,
    input  logic [REG_ADDR_W-1:0]   rs2_d_i,
    input  logic [REG_ADDR_W-1:0]   rd_e_i,
    input  logic                    reg_write_e_i,
    input  logic [RESULT_SRC_W-1:0] result_src_e_i,
    input  logic [REG_ADDR_W-1:0]   rs1_e_i,
    input  logic [REG_ADDR_W-1:0]   rs2_e_i,
    input  logic [REG_ADDR_W-1:0]   rd_m_i,
    input  logic                    reg_write_m_i,
    input  logic [REG_ADDR_W-1:0]   rd_w_i,
    input  logic                    reg_write_w_i,
    input  pcsrc_e                  pcsrc_i,
    output logic                    load_use_o,
    output logic                    flush_o,
    output logic                    stall_f_o,
    output fwd_sel_e                fwd_a_o,
    output fwd_sel_e                fwd_b_o
);

    localparam logic [REG_ADDR_W-1:0] X0 = {REG_ADDR_W{1'b0}};

    // The younger producer (M) wins over the older one (W); x0 never forwards.
    function automatic fwd_sel_e fwd_pick(input logic [REG_ADDR_W-1:0] rs);
        fwd_sel_e sel;
        if (reg_write_m_i && (rd_m_i != X0) && (rd_m_i == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != X0) && (rd_w_i == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard decisions from the current stage-register contents.
    always_comb begin
        load_use_o = 1'b0;
        flush_o    = 1'b0;
        stall_f_o  = 1'b0;
        fwd_a_o    = FWD_RF;
        fwd_b_o    = FWD_RF;

        load_use_o = (result_src_e_i == RES_LOAD) && reg_write_e_i && (rd_e_i != X0) &&
                     ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
        flush_o    = (pcsrc_i != PCSRC_PLUS4);
        // A redirect overrides the stall: the stalled instruction is being squashed anyway.
        if (flush_o) begin
            stall_f_o = 1'b0;
        end else begin
            stall_f_o = load_use_o;
        end
        fwd_a_o = fwd_pick(rs1_e_i);
        fwd_b_o = fwd_pick(rs2_e_i);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: F/D instruction register, D->E->M->W control bundles,
// branch resolution in E, hazard handling and a saturating hazard-event counter.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int ALU_CTRL_WIDTH   = 4,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int CNT_WIDTH        = 16
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
    logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
    logic [DATA_WIDTH-1:0] pcp4_d_q, pcp4_d_d;
    ctrl_bundle_t          ctrl_d_s;
    ctrl_bundle_t          ctrl_e_q, ctrl_e_d;
    ctrl_bundle_t          ctrl_m_q, ctrl_m_d;
    ctrl_bundle_t          ctrl_w_q, ctrl_w_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    pcsrc_e                pcsrc_s;
    logic                  load_use_s, flush_s, stall_f_s;
    fwd_sel_e              fwd_a_s, fwd_b_s;
    logic                  unused_w_s;

    // Assemble the D-stage bundle from the decoder and the D instruction fields.
    always_comb begin
        ctrl_d_s            = BUBBLE;
        ctrl_d_s.reg_write  = bus.RegWriteD_i;
        ctrl_d_s.mem_write  = bus.MemWriteD_i;
        ctrl_d_s.result_src = RESULT_SRC_W'(bus.ResultSrcD_i);
        ctrl_d_s.alu_ctrl   = ALU_CTRL_W'(bus.ALUControlD_i);
        ctrl_d_s.alu_src    = bus.ALUSrcD_i;
        ctrl_d_s.branch     = bus.BranchD_i;
        ctrl_d_s.jump       = bus.JumpD_i;
        ctrl_d_s.rd         = instr_d_q[11:7];
        ctrl_d_s.rs1        = instr_d_q[19:15];
        ctrl_d_s.rs2        = instr_d_q[24:20];
        ctrl_d_s.funct3     = instr_d_q[14:12];
    end

    // Resolve the next-PC source for the instruction in E.
    always_comb begin
        pcsrc_s = PCSRC_PLUS4;
        if (ctrl_e_q.jump == JUMP_JALR) begin
            pcsrc_s = PCSRC_ALU;
        end else if ((ctrl_e_q.jump == JUMP_JAL) ||
                     (ctrl_e_q.branch &&
                      branch_cond(ctrl_e_q.funct3, bus.ZeroE_i, bus.LtE_i, bus.LtuE_i))) begin
            pcsrc_s = PCSRC_TARGET;
        end else begin
            pcsrc_s = PCSRC_PLUS4;
        end
    end

    hazard_unit u_hazard (
        .rs1_d_i        (instr_d_q[19:15]),
        .rs2_d_i        (instr_d_q[24:20]),
        .rd_e_i         (ctrl_e_q.rd),
        .reg_write_e_i  (ctrl_e_q.reg_write),
        .result_src_e_i (ctrl_e_q.result_src),
        .rs1_e_i        (ctrl_e_q.rs1),
        .rs2_e_i        (ctrl_e_q.rs2),
        .rd_m_i         (ctrl_m_q.rd),
        .reg_write_m_i  (ctrl_m_q.reg_write),
        .rd_w_i         (ctrl_w_q.rd),
        .reg_write_w_i  (ctrl_w_q.reg_write),
        .pcsrc_i        (pcsrc_s),
        .load_use_o     (load_use_s),
        .flush_o        (flush_s),
        .stall_f_o      (stall_f_s),
        .fwd_a_o        (fwd_a_s),
        .fwd_b_o        (fwd_b_s)
    );

    // Next-state for stage registers and counter: flush beats load-use beats advance.
    always_comb begin
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pcp4_d_d  = pcp4_d_q;
        ctrl_e_d  = ctrl_d_s;
        ctrl_m_d  = ctrl_e_q;
        ctrl_w_d  = ctrl_m_q;
        cnt_d     = cnt_q;

        if (flush_s) begin
            instr_d_d = DATA_WIDTH'(NOP_INSTR);
            pc_d_d    = {DATA_WIDTH{1'b0}};
            pcp4_d_d  = {DATA_WIDTH{1'b0}};
            ctrl_e_d  = BUBBLE;
        end else if (load_use_s) begin
            ctrl_e_d  = BUBBLE;
        end else begin
            instr_d_d = bus.InstrF_i;
            pc_d_d    = bus.PCF_i;
            pcp4_d_d  = bus.PCPlus4F_i;
        end

        if ((flush_s || load_use_s) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage registers; reset loads a NOP in D and bubbles everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d_q <= DATA_WIDTH'(NOP_INSTR);
            pc_d_q    <= {DATA_WIDTH{1'b0}};
            pcp4_d_q  <= {DATA_WIDTH{1'b0}};
            ctrl_e_q  <= BUBBLE;
            ctrl_m_q  <= BUBBLE;
            ctrl_w_q  <= BUBBLE;
            cnt_q     <= {CNT_WIDTH{1'b0}};
        end else begin
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            pcp4_d_q  <= pcp4_d_d;
            ctrl_e_q  <= ctrl_e_d;
            ctrl_m_q  <= ctrl_m_d;
            ctrl_w_q  <= ctrl_w_d;
            cnt_q     <= cnt_d;
        end
    end

    // W only needs writeback fields; the rest of its bundle is deliberately dropped.
    assign unused_w_s = ^{ctrl_w_q.mem_write, ctrl_w_q.alu_ctrl, ctrl_w_q.alu_src,
                          ctrl_w_q.branch, ctrl_w_q.jump, ctrl_w_q.rs1, ctrl_w_q.rs2,
                          ctrl_w_q.funct3};

    assign bus.InstrD_o      = instr_d_q;
    assign bus.PCD_o         = pc_d_q;
    assign bus.PCPlus4D_o    = pcp4_d_q;
    assign bus.ALUControlE_o = ALU_CTRL_WIDTH'(ctrl_e_q.alu_ctrl);
    assign bus.ALUSrcE_o     = ctrl_e_q.alu_src;
    assign bus.MemWriteM_o   = ctrl_m_q.mem_write;
    assign bus.funct3M_o     = ctrl_m_q.funct3;
    assign bus.RegWriteW_o   = ctrl_w_q.reg_write;
    assign bus.ResultSrcW_o  = RESULT_SRC_WIDTH'(ctrl_w_q.result_src);
    assign bus.RdW_o         = REG_ADDR_WIDTH'(ctrl_w_q.rd);
    assign bus.PCSrcE_o      = pcsrc_s;
    assign bus.StallF_o      = stall_f_s;
    assign bus.ForwardAE_o   = fwd_a_s;
    assign bus.ForwardBE_o   = fwd_b_s;
    assign bus.HazardCnt_o   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized bench for ctrl_pipe against an instruction-level pipeline model,
// plus directed hazard scenarios. A 4-bit counter makes saturation reachable.
module tb_ctrl_pipe;

    localparam int          CW      = 4;
    localparam int          CNT_MAX = 15;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic       rw;
        logic [1:0] mw;
        logic [1:0] rs;
        logic [3:0] alu;
        logic       as;
        logic       br;
        logic [1:0] j;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] f3;
    } slot_t;

    localparam slot_t BUB = '0;

    logic clk;
    logic rst;
    ctrl_pipe_if #(.CNT_WIDTH(CW)) bus ();

    ctrl_pipe #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what each stage holds, as instruction-level records.
    logic [31:0] m_instr_d, m_pc_d, m_pcp4_d;
    slot_t       m_e, m_m, m_w;
    int          m_cnt;
    logic [31:0] pc_r;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tb_cond(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        logic flag;
        if (f3[2:1] == 2'b00)      flag = z;
        else if (f3[2:1] == 2'b10) flag = lt;
        else if (f3[2:1] == 2'b11) flag = ltu;
        else return 1'b0;
        return flag ^ f3[0];
    endfunction

    function automatic int m_pcsrc();
        if (m_e.j == 2'd2) return 2;
        if (m_e.j == 2'd1) return 1;
        if (m_e.br && tb_cond(m_e.f3, bus.ZeroE_i, bus.LtE_i, bus.LtuE_i)) return 1;
        return 0;
    endfunction

    function automatic logic m_lu();
        return (m_e.rs == 2'd1) && m_e.rw && (m_e.rd != 5'd0) &&
               ((m_e.rd == m_instr_d[19:15]) || (m_e.rd == m_instr_d[24:20]));
    endfunction

    function automatic int m_fwd(input logic [4:0] rs);
        if (m_m.rw && m_m.rd != 5'd0 && m_m.rd == rs) return 2;
        if (m_w.rw && m_w.rd != 5'd0 && m_w.rd == rs) return 1;
        return 0;
    endfunction

    function automatic slot_t mk(input logic rw, input logic [1:0] rs, input logic [3:0] alu,
                                 input logic br, input logic [1:0] j);
        slot_t s;
        s     = BUB;
        s.rw  = rw;
        s.rs  = rs;
        s.alu = alu;
        s.br  = br;
        s.j   = j;
        return s;
    endfunction

    task automatic model_reset();
        m_instr_d = NOP;
        m_pc_d    = 32'd0;
        m_pcp4_d  = 32'd0;
        m_e       = BUB;
        m_m       = BUB;
        m_w       = BUB;
        m_cnt     = 0;
    endtask

    task automatic drive(input logic [31:0] instr, input slot_t c,
                         input logic z, input logic lt, input logic ltu);
        bus.InstrF_i      = instr;
        bus.PCF_i         = pc_r;
        bus.PCPlus4F_i    = pc_r + 32'd4;
        pc_r              = pc_r + 32'd4;
        bus.RegWriteD_i   = c.rw;
        bus.MemWriteD_i   = c.mw;
        bus.ResultSrcD_i  = c.rs;
        bus.ALUControlD_i = c.alu;
        bus.ALUSrcD_i     = c.as;
        bus.BranchD_i     = c.br;
        bus.JumpD_i       = c.j;
        bus.ZeroE_i       = z;
        bus.LtE_i         = lt;
        bus.LtuE_i        = ltu;
        #1;
    endtask

    task automatic check_model();
        int  pcs;
        logic lu;
        pcs = m_pcsrc();
        lu  = m_lu();
        check_val("instr_d", bus.InstrD_o, m_instr_d);
        check_val("pc_d", bus.PCD_o, m_pc_d);
        check_val("pcp4_d", bus.PCPlus4D_o, m_pcp4_d);
        check_val("alu_e", bus.ALUControlE_o, m_e.alu);
        check_val("alusrc_e", bus.ALUSrcE_o, m_e.as);
        check_val("memwr_m", bus.MemWriteM_o, m_m.mw);
        check_val("f3_m", bus.funct3M_o, m_m.f3);
        check_val("regwr_w", bus.RegWriteW_o, m_w.rw);
        check_val("ressrc_w", bus.ResultSrcW_o, m_w.rs);
        check_val("rd_w", bus.RdW_o, m_w.rd);
        check_val("pcsrc", bus.PCSrcE_o, pcs);
        check_val("stall_f", bus.StallF_o, (lu && pcs == 0) ? 1 : 0);
        check_val("fwd_a", bus.ForwardAE_o, m_fwd(m_e.rs1));
        check_val("fwd_b", bus.ForwardBE_o, m_fwd(m_e.rs2));
        check_val("hcnt", bus.HazardCnt_o, m_cnt);
    endtask

    // Apply one clock of the spec's stage rules to the model, then move to the next cycle.
    task automatic advance();
        slot_t ds;
        logic  flush, lu;
        flush  = (m_pcsrc() != 0);
        lu     = m_lu();
        ds     = mk(bus.RegWriteD_i, bus.ResultSrcD_i, bus.ALUControlD_i, bus.BranchD_i, bus.JumpD_i);
        ds.mw  = bus.MemWriteD_i;
        ds.as  = bus.ALUSrcD_i;
        ds.rd  = m_instr_d[11:7];
        ds.rs1 = m_instr_d[19:15];
        ds.rs2 = m_instr_d[24:20];
        ds.f3  = m_instr_d[14:12];
        m_w = m_m;
        m_m = m_e;
        if (flush) begin
            m_e       = BUB;
            m_instr_d = NOP;
            m_pc_d    = 32'd0;
            m_pcp4_d  = 32'd0;
        end else if (lu) begin
            m_e = BUB;
        end else begin
            m_e       = ds;
            m_instr_d = bus.InstrF_i;
            m_pc_d    = bus.PCF_i;
            m_pcp4_d  = bus.PCPlus4F_i;
        end
        if ((flush || lu) && m_cnt < CNT_MAX) m_cnt++;
        @(negedge clk);
    endtask

    task automatic cyc(input logic [31:0] instr, input slot_t c,
                       input logic z, input logic lt, input logic ltu);
        drive(instr, c, z, lt, ltu);
        check_model();
        advance();
    endtask

    task automatic branch_case(input string tag, input logic [2:0] f3, input logic [1:0] j,
                               input logic z, input logic lt, input logic ltu, input int exp);
        cyc({7'd0, 5'd2, 5'd1, f3, 5'd0, 7'h63}, BUB, 1'b0, 1'b0, 1'b0);
        cyc(NOP, mk(1'b0, 2'd0, 4'h3, (j == 2'd0), j), 1'b0, 1'b0, 1'b0);
        drive(NOP, BUB, z, lt, ltu);
        check_model();
        check_val(tag, bus.PCSrcE_o, exp);
        advance();
        drive(NOP, BUB, 1'b0, 1'b0, 1'b0);
        check_model();
        if (exp != 0) begin
            check_val({tag, "_flush_d"}, bus.InstrD_o, NOP);
            check_val({tag, "_flush_e"}, bus.ALUControlE_o, 0);
        end
        advance();
    endtask

    task automatic fwd_case(input string tag, input logic [4:0] r, input int exp);
        slot_t wr;
        wr = mk(1'b1, 2'd0, 4'h0, 1'b0, 2'd0);
        cyc({7'd0, 5'd2, 5'd1, 3'd0, r, 7'h33}, BUB, 1'b0, 1'b0, 1'b0);
        cyc({7'd0, 5'd2, 5'd1, 3'd0, r, 7'h33}, wr, 1'b0, 1'b0, 1'b0);
        cyc({7'h20, r, r, 3'd0, 5'd4, 7'h33}, wr, 1'b0, 1'b0, 1'b0);
        cyc(NOP, wr, 1'b0, 1'b0, 1'b0);
        drive(NOP, BUB, 1'b0, 1'b0, 1'b0);
        check_model();
        check_val({tag, "_a"}, bus.ForwardAE_o, exp);
        check_val({tag, "_b"}, bus.ForwardBE_o, exp);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("areset_instr_d", bus.InstrD_o, NOP);
        check_val("areset_cnt", bus.HazardCnt_o, 0);
        check_val("areset_regwr_w", bus.RegWriteW_o, 0);
        model_reset();
        rst = 1'b0;
    endtask

    localparam logic [31:0] LW   = {12'd0, 5'd1, 3'b010, 5'd5, 7'h03};
    localparam logic [31:0] ADD  = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] JALR = {12'd0, 5'd1, 3'd0, 5'd5, 7'h67};

    initial begin
        int exp_cnt;
        slot_t rc;
        logic [31:0] ri;
        pc_r = 32'h100;
        rst  = 1'b1;
        drive(32'd0, BUB, 1'b0, 1'b0, 1'b0);
        #2;
        check_val("rst_instr_d", bus.InstrD_o, NOP);
        check_val("rst_pc_d", bus.PCD_o, 0);
        check_val("rst_pcsrc", bus.PCSrcE_o, 0);
        check_val("rst_stall", bus.StallF_o, 0);
        check_val("rst_cnt", bus.HazardCnt_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // lw x5,0(x1) ; add x6,x5,x2
        cyc(LW, BUB, 1'b0, 1'b0, 1'b0);
        cyc(ADD, mk(1'b1, 2'd1, 4'h0, 1'b0, 2'd0), 1'b0, 1'b0, 1'b0);
        drive(NOP, mk(1'b1, 2'd0, 4'hA, 1'b0, 2'd0), 1'b0, 1'b0, 1'b0);
        check_model();
        check_val("lu_stall", bus.StallF_o, 1);
        advance();
        drive(NOP, mk(1'b1, 2'd0, 4'hA, 1'b0, 2'd0), 1'b0, 1'b0, 1'b0);
        check_model();
        check_val("lu_hold_d", bus.InstrD_o, ADD);
        check_val("lu_bubble_e", bus.ALUControlE_o, 0);
        check_val("lu_stall_off", bus.StallF_o, 0);
        check_val("lu_cnt", bus.HazardCnt_o, 1);
        advance();
        drive(NOP, BUB, 1'b0, 1'b0, 1'b0);
        check_model();
        check_val("lu_fwd_a", bus.ForwardAE_o, 1);
        advance();

        branch_case("beq_taken", 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 1);
        branch_case("bne_zero", 3'b001, 2'd0, 1'b1, 1'b0, 1'b0, 0);
        branch_case("bltu_taken", 3'b110, 2'd0, 1'b0, 1'b0, 1'b1, 1);
        branch_case("bge_lt", 3'b101, 2'd0, 1'b0, 1'b1, 1'b0, 0);
        branch_case("f3_010", 3'b010, 2'd0, 1'b1, 1'b1, 1'b1, 0);
        branch_case("jal", 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 1);

        // JALR in E while its load-like destination collides with D
        cyc(JALR, BUB, 1'b0, 1'b0, 1'b0);
        cyc(ADD, mk(1'b1, 2'd1, 4'h0, 1'b0, 2'd2), 1'b0, 1'b0, 1'b0);
        drive(NOP, mk(1'b1, 2'd0, 4'hA, 1'b0, 2'd0), 1'b0, 1'b0, 1'b0);
        check_model();
        check_val("jalr_pcsrc", bus.PCSrcE_o, 2);
        check_val("jalr_stall", bus.StallF_o, 0);
        exp_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        advance();
        drive(NOP, BUB, 1'b0, 1'b0, 1'b0);
        check_model();
        check_val("jalr_flush_d", bus.InstrD_o, NOP);
        check_val("jalr_flush_e", bus.ALUControlE_o, 0);
        check_val("jalr_cnt", bus.HazardCnt_o, exp_cnt);
        advance();

        fwd_case("fwd_m_wins", 5'd3, 2);
        fwd_case("fwd_x0", 5'd0, 0);

        // Randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            ri = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  3'($urandom), 5'($urandom_range(0, 3)), 7'($urandom)};
            rc     = BUB;
            rc.rw  = 1'($urandom);
            rc.mw  = 2'($urandom);
            rc.rs  = 2'($urandom_range(0, 3));
            if (rc.rs == 2'd3) rc.rs = 2'd1;
            rc.alu = 4'($urandom);
            rc.as  = 1'($urandom);
            rc.br  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       rc.j = 2'd1;
                1:       rc.j = 2'd2;
                default: rc.j = 2'd0;
            endcase
            drive(ri, rc, 1'($urandom), 1'($urandom), 1'($urandom));
            if (i % 300 == 150) do_reset();
            check_model();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
